// File: rtl/arb_mux_pkg.sv
// Shared types and helpers for the arbitrated multiplexer.
//   arb_mode_e : arbitration policy selector (round-robin or fixed priority)
//   next_ptr   : round-robin pointer successor with explicit modulo wrap
package arb_mux_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  // Successor of idx in a ring of `channels` entries. The wrap is explicit so
  // non-power-of-two channel counts never land on an unused index.
  function automatic int unsigned next_ptr(input int unsigned idx,
                                           input int unsigned channels);
    if (idx + 32'd1 >= channels) begin
      return 32'd0;
    end
    return idx + 32'd1;
  endfunction

endpackage : arb_mux_pkg

// File: rtl/rr_arbiter.sv
// Request arbiter for arb_mux. Picks one requester per cycle, either
// round-robin from a rotating priority pointer or fixed lowest-index-wins.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-channel request vector
//   advance    : a granted transfer happened this cycle; rotate the pointer
//   grant      : one-hot (or zero) grant vector, combinational from req/ptr
//   grant_id   : binary index of the granted channel
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned ID_W     = ($clog2(CHANNELS) > 0) ? $clog2(CHANNELS) : 1,
  parameter arb_mode_e   ARB_MODE = ARB_RR
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] req,
  input  logic                advance,
  output logic [CHANNELS-1:0] grant,
  output logic [ID_W-1:0]     grant_id
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] idx;
  logic            found;

  // Priority search: start at ptr (or 0 in fixed mode) and ascend with wrap.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (ARB_MODE == ARB_FIXED) begin
        idx = ID_W'(k);
      end else begin
        idx = ID_W'((32'(ptr) + k) % CHANNELS);
      end
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

  // Pointer moves just past the last winner; it stays 0 in fixed mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if ((ARB_MODE == ARB_RR) && advance) begin
      ptr <= ID_W'(next_ptr(32'(grant_id), CHANNELS));
    end
  end

endmodule : rr_arbiter

// File: rtl/arb_mux.sv
// N-channel arbitrated multiplexer with valid/ready handshakes on every input
// and a single registered output stage that holds its word until accepted.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : per-channel request
//   in_data    : per-channel payload
//   in_ready   : per-channel accept (at most one high), combinational
//   out_valid  : output register holds a word
//   out_data   : registered payload
//   out_id     : source channel of out_data
//   out_ready  : downstream accept
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned ID_W     = ($clog2(CHANNELS) > 0) ? $clog2(CHANNELS) : 1,
  parameter arb_mode_e   ARB_MODE = ARB_RR
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] in_valid,
  input  logic [WIDTH-1:0]    in_data [CHANNELS],
  output logic [CHANNELS-1:0] in_ready,
  output logic                out_valid,
  output logic [WIDTH-1:0]    out_data,
  output logic [ID_W-1:0]     out_id,
  input  logic                out_ready
);

  logic                load_en;
  logic                xfer;
  logic [CHANNELS-1:0] grant;
  logic [ID_W-1:0]     grant_id;

  // Register can take a word when empty or being drained this cycle; the
  // rst_n term keeps every in_ready low while reset is asserted.
  assign load_en  = rst_n && (!out_valid || out_ready);
  assign in_ready = grant & {CHANNELS{load_en}};
  assign xfer     = |(in_valid & in_ready);

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .ID_W     (ID_W),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (in_valid),
    .advance  (xfer),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Output register: load on transfer, otherwise drop valid once accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[grant_id];
      out_id    <= grant_id;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule : arb_mux

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: 4-channel round-robin, 4-channel fixed
// priority and 3-channel round-robin instances sharing clock and reset.
module tb_arb_mux;
  import arb_mux_pkg::*;

  logic clk;
  logic rst_n;
  int   vecs;
  int   errs;

  logic [3:0] rr_valid, rr_ready;
  logic [7:0] rr_data [4];
  logic       rr_ov, rr_ordy;
  logic [7:0] rr_od;
  logic [1:0] rr_oid;

  logic [3:0] fx_valid, fx_ready;
  logic [7:0] fx_data [4];
  logic       fx_ov, fx_ordy;
  logic [7:0] fx_od;
  logic [1:0] fx_oid;

  logic [2:0] np_valid, np_ready;
  logic [7:0] np_data [3];
  logic       np_ov, np_ordy;
  logic [7:0] np_od;
  logic [1:0] np_oid;

  arb_mux #(.WIDTH(8), .CHANNELS(4), .ARB_MODE(ARB_RR)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(rr_valid), .in_data(rr_data),
    .in_ready(rr_ready), .out_valid(rr_ov), .out_data(rr_od),
    .out_id(rr_oid), .out_ready(rr_ordy));

  arb_mux #(.WIDTH(8), .CHANNELS(4), .ARB_MODE(ARB_FIXED)) u_fx (
    .clk(clk), .rst_n(rst_n), .in_valid(fx_valid), .in_data(fx_data),
    .in_ready(fx_ready), .out_valid(fx_ov), .out_data(fx_od),
    .out_id(fx_oid), .out_ready(fx_ordy));

  arb_mux #(.WIDTH(8), .CHANNELS(3), .ARB_MODE(ARB_RR)) u_np (
    .clk(clk), .rst_n(rst_n), .in_valid(np_valid), .in_data(np_data),
    .in_ready(np_ready), .out_valid(np_ov), .out_data(np_od),
    .out_id(np_oid), .out_ready(np_ordy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    rr_valid = 4'hF;
    rr_ordy  = 1'b1;
    for (int i = 0; i < 4; i++) rr_data[i] = 8'hA0 | 8'(i);
    repeat (2) @(posedge clk);
    #1;
    vecs++; if (rr_ov !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %0b want 0", rr_ov); end
    vecs++; if (rr_ready !== 4'b0000) begin errs++; $display("FAIL reset_in_ready: got %b want 0000", rr_ready); end
    vecs++; if (rr_od !== 8'h00 || rr_oid !== 2'd0) begin errs++; $display("FAIL reset_out_regs: got data %h id %0d want 00/0", rr_od, rr_oid); end
    rst_n = 1'b1;
    #1;
    vecs++; if (rr_ready !== 4'b0001) begin errs++; $display("FAIL first_grant_ready: got %b want 0001", rr_ready); end
    tick;
    vecs++; if (rr_ov !== 1'b1 || rr_oid !== 2'd0 || rr_od !== 8'hA0) begin
      errs++; $display("FAIL first_word: got v%0b id %0d data %h want v1 id 0 data a0", rr_ov, rr_oid, rr_od);
    end
  endtask

  task automatic test_rr_fairness;
    logic [1:0] exp_id;
    for (int n = 0; n < 5; n++) begin
      tick;
      exp_id = 2'(n + 1);
      vecs++; if (rr_ov !== 1'b1 || rr_oid !== exp_id || rr_od !== (8'hA0 | 8'(exp_id))) begin
        errs++; $display("FAIL rr_seq[%0d]: got v%0b id %0d data %h want v1 id %0d", n, rr_ov, rr_oid, rr_od, exp_id);
      end
    end
  endtask

  task automatic test_sparse;
    logic [1:0] e_id [3];
    logic [7:0] e_dat [3];
    e_id  = '{2'd3, 2'd1, 2'd3};
    e_dat = '{8'hA3, 8'hA5, 8'hA3};
    rr_valid   = 4'b1010;
    rr_data[1] = 8'hA5;
    for (int n = 0; n < 3; n++) begin
      tick;
      vecs++; if (rr_oid !== e_id[n] || rr_od !== e_dat[n] || rr_ov !== 1'b1) begin
        errs++; $display("FAIL sparse[%0d]: got id %0d data %h v%0b want id %0d data %h", n, rr_oid, rr_od, rr_ov, e_id[n], e_dat[n]);
      end
    end
  endtask

  task automatic test_backpressure;
    rr_valid   = 4'hF;
    rr_data[1] = 8'hA1;
    rr_ordy    = 1'b0;
    #1;
    vecs++; if (rr_ready !== 4'b0000) begin errs++; $display("FAIL bp_ready_initial: got %b want 0000", rr_ready); end
    for (int n = 0; n < 3; n++) begin
      tick;
      vecs++; if (rr_ov !== 1'b1 || rr_oid !== 2'd3 || rr_od !== 8'hA3 || rr_ready !== 4'b0000) begin
        errs++; $display("FAIL bp_hold[%0d]: got v%0b id %0d data %h ready %b want v1 id 3 data a3 ready 0000", n, rr_ov, rr_oid, rr_od, rr_ready);
      end
    end
    rr_ordy = 1'b1;
    #1;
    vecs++; if (rr_ready !== 4'b0001) begin errs++; $display("FAIL bp_release_ready: got %b want 0001", rr_ready); end
    tick;
    vecs++; if (rr_ov !== 1'b1 || rr_oid !== 2'd0 || rr_od !== 8'hA0) begin
      errs++; $display("FAIL bp_release_load: got v%0b id %0d data %h want v1 id 0 data a0", rr_ov, rr_oid, rr_od);
    end
    rr_valid = 4'h0;
    tick;
    vecs++; if (rr_ov !== 1'b0 || rr_oid !== 2'd0 || rr_od !== 8'hA0) begin
      errs++; $display("FAIL drain: got v%0b id %0d data %h want v0 id 0 data a0", rr_ov, rr_oid, rr_od);
    end
  endtask

  task automatic test_fixed;
    for (int i = 0; i < 4; i++) fx_data[i] = 8'hC0 | 8'(i);
    fx_ordy  = 1'b1;
    fx_valid = 4'b0101;
    #1;
    vecs++; if (fx_ready !== 4'b0001) begin errs++; $display("FAIL fixed_ready_initial: got %b want 0001", fx_ready); end
    for (int n = 0; n < 4; n++) begin
      tick;
      vecs++; if (fx_ov !== 1'b1 || fx_oid !== 2'd0 || fx_od !== 8'hC0 || fx_ready !== 4'b0001) begin
        errs++; $display("FAIL fixed[%0d]: got v%0b id %0d data %h ready %b want v1 id 0 data c0 ready 0001", n, fx_ov, fx_oid, fx_od, fx_ready);
      end
      vecs++; if (u_fx.u_arb.ptr !== 2'd0) begin errs++; $display("FAIL fixed_ptr[%0d]: got %0d want 0", n, u_fx.u_arb.ptr); end
    end
    fx_valid = 4'b0000;
  endtask

  task automatic test_npot;
    logic [1:0] exp_id;
    logic [1:0] exp_ptr;
    for (int i = 0; i < 3; i++) np_data[i] = 8'hD0 | 8'(i);
    np_ordy  = 1'b1;
    np_valid = 3'b111;
    for (int n = 0; n < 4; n++) begin
      tick;
      exp_id  = 2'(n % 3);
      exp_ptr = 2'((n + 1) % 3);
      vecs++; if (np_ov !== 1'b1 || np_oid !== exp_id || np_od !== (8'hD0 | 8'(exp_id))) begin
        errs++; $display("FAIL npot[%0d]: got v%0b id %0d data %h want v1 id %0d", n, np_ov, np_oid, np_od, exp_id);
      end
      vecs++; if (u_np.u_arb.ptr !== exp_ptr) begin
        errs++; $display("FAIL npot_ptr[%0d]: got %0d want %0d", n, u_np.u_arb.ptr, exp_ptr);
      end
    end
    // Mid-cycle asynchronous reset with a word held in the register.
    #2;
    rst_n = 1'b0;
    #1;
    vecs++; if (np_ov !== 1'b0 || np_od !== 8'h00 || np_oid !== 2'd0) begin
      errs++; $display("FAIL async_reset_out: got v%0b data %h id %0d want v0 data 00 id 0", np_ov, np_od, np_oid);
    end
    vecs++; if (np_ready !== 3'b000 || u_np.u_arb.ptr !== 2'd0) begin
      errs++; $display("FAIL async_reset_arb: got ready %b ptr %0d want 000/0", np_ready, u_np.u_arb.ptr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    vecs++; if (np_ov !== 1'b1 || np_oid !== 2'd0 || np_od !== 8'hD0) begin
      errs++; $display("FAIL post_reset_word: got v%0b id %0d data %h want v1 id 0 data d0", np_ov, np_oid, np_od);
    end
  endtask

  initial begin
    vecs     = 0;
    errs     = 0;
    rst_n    = 1'b0;
    rr_valid = '0;
    rr_ordy  = 1'b1;
    fx_valid = '0;
    fx_ordy  = 1'b1;
    np_valid = '0;
    np_ordy  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rr_data[i] = '0;
      fx_data[i] = '0;
    end
    for (int i = 0; i < 3; i++) np_data[i] = '0;

    test_reset;
    test_rr_fairness;
    test_sparse;
    test_backpressure;
    test_fixed;
    test_npot;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule : tb_arb_mux
